// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, default latencies, FSM state type.
// Also consumed by the decoder and hazard unit, so encodings must stay stable.
// Contents: OP_* codes (4 b), default cycle counts, mdu_state_e, is_long_op().
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // Ops that occupy the unit for a multi-cycle busy window.
    function automatic logic is_long_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) ||
               (op == OP_DIV)  || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/e_mdu_if.sv
// E-stage <-> MDU bundle: op issue (start/mdu_op/rs/rt) and status/read-back (busy/out).
// master = pipeline side driving the operation; slave = the MDU.
// No clock inside; the MDU samples on its own clk.
interface e_mdu_if;
    logic        start;
    logic [3:0]  mdu_op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] out;

    modport master (output start, mdu_op, rs, rt, input  busy, out);
    modport slave  (input  start, mdu_op, rs, rt, output busy, out);
endinterface

// File: rtl/e_mdu.sv
// Multiply/divide unit with HI/LO registers for a MIPS-style E stage.
// Latency: HI/LO update MULT_CYCLES / DIV_CYCLES edges after the start edge; MT*/MF* are immediate.
// Backpressure: busy stalls the D stage; a start arriving while busy is dropped entirely.
// Ports: clk, reset (async, active-high); mdu (e_mdu_if.slave): start, mdu_op, rs, rt in; busy, out out.
module e_mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic     clk,
    input  logic     reset,
    e_mdu_if.slave   mdu
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    mdu_state_e  state_q, state_d;
    cnt_t        cnt_q,   cnt_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    hilo_t       pend_q,  pend_d;

    // ------------------------------------------------------------------
    // Arithmetic, evaluated combinationally from the issuing operands.
    // ------------------------------------------------------------------
    logic signed [63:0] s_prod;
    logic        [63:0] u_prod;
    logic               div_zero;
    logic               s_ovf;
    logic signed [31:0] s_den;
    logic signed [31:0] s_quo;
    logic signed [31:0] s_rem;
    logic        [31:0] u_den;
    logic        [31:0] u_quo;
    logic        [31:0] u_rem;

    assign s_prod   = $signed({{32{mdu.rs[31]}}, mdu.rs}) * $signed({{32{mdu.rt[31]}}, mdu.rt});
    assign u_prod   = {32'd0, mdu.rs} * {32'd0, mdu.rt};
    assign div_zero = (mdu.rt == 32'd0);
    // 0x80000000 / -1 overflows the quotient; pin it to the wrapped value so
    // simulation models never evaluate the undefined case.
    assign s_ovf    = (mdu.rs == 32'h8000_0000) && (mdu.rt == 32'hFFFF_FFFF);

    // Divisors are forced to 1 in the degenerate cases; those results are discarded.
    assign s_den = (div_zero || s_ovf) ? 32'sd1 : $signed(mdu.rt);
    assign u_den = div_zero ? 32'd1 : mdu.rt;

    always_comb begin
        s_quo = $signed(mdu.rs) / s_den;   // truncates toward zero
        s_rem = $signed(mdu.rs) % s_den;   // sign follows the dividend
        if (s_ovf) begin
            s_quo = 32'sh8000_0000;
            s_rem = 32'sd0;
        end
    end

    assign u_quo = mdu.rs / u_den;
    assign u_rem = mdu.rs % u_den;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;

        unique case (state_q)
            ST_IDLE: begin
                if (mdu.start) begin
                    case (mdu.mdu_op)
                        OP_MULT: begin
                            pend_d  = s_prod;
                            cnt_d   = cnt_t'(MULT_CYCLES);
                            state_d = ST_RUN;
                        end
                        OP_MULTU: begin
                            pend_d  = u_prod;
                            cnt_d   = cnt_t'(MULT_CYCLES);
                            state_d = ST_RUN;
                        end
                        OP_DIV: begin
                            // Divide by zero still burns the full window but
                            // commits the current HI/LO back unchanged.
                            pend_d  = div_zero ? hilo_t'({hi_q, lo_q})
                                               : hilo_t'({s_rem, s_quo});
                            cnt_d   = cnt_t'(DIV_CYCLES);
                            state_d = ST_RUN;
                        end
                        OP_DIVU: begin
                            pend_d  = div_zero ? hilo_t'({hi_q, lo_q})
                                               : hilo_t'({u_rem, u_quo});
                            cnt_d   = cnt_t'(DIV_CYCLES);
                            state_d = ST_RUN;
                        end
                        OP_MTHI: hi_d = mdu.rs;
                        OP_MTLO: lo_d = mdu.rs;
                        default: ;   // NONE, MFHI, MFLO, 9-15: no state change
                    endcase
                end
            end

            ST_RUN: begin
                // start is ignored here; the counter only models latency.
                if (cnt_q <= cnt_t'(1)) begin
                    cnt_d   = '0;
                    hi_d    = pend_q.hi;
                    lo_d    = pend_q.lo;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: read-back never bypasses the pending result.
    // ------------------------------------------------------------------
    assign mdu.busy = (state_q == ST_RUN);

    always_comb begin
        mdu.out = 32'd0;
        if (mdu.mdu_op == OP_MFHI) mdu.out = hi_q;
        else if (mdu.mdu_op == OP_MFLO) mdu.out = lo_q;
    end

endmodule
